// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants, opcode encodings and FSM states for div_unit
package div_pkg;
    localparam int XLEN  = 64;
    localparam int ITER  = 64;
    localparam int CNT_W = 7;

    localparam logic [1:0] DIV_OP  = 2'b00;
    localparam logic [1:0] DIVU_OP = 2'b01;
    localparam logic [1:0] REM_OP  = 2'b10;
    localparam logic [1:0] REMU_OP = 2'b11;

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;
endpackage

// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - launch/result handshake bundle of div_unit (word port under DIV_UNIT_WORD_EN)
interface div_unit_if;
    import div_pkg::*;

    logic            start;
    logic            kill;
    logic [1:0]      func;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] s;
`ifdef DIV_UNIT_WORD_EN
    logic            word;

    modport master (output start, kill, func, a, b, word, input busy, done, s);
    modport slave  (input start, kill, func, a, b, word, output busy, done, s);
`else
    modport master (output start, kill, func, a, b, input busy, done, s);
    modport slave  (input start, kill, func, a, b, output busy, done, s);
`endif
endinterface

// File: rtl/add64.sv
// rtl/add64.sv - 64-bit adder with carry in/out
module add64 (
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    input  logic        cin_i,
    output logic [63:0] sum_o,
    output logic        cout_o
);
    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {64'd0, cin_i};
endmodule

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step
    import div_pkg::*;
(
    input  logic [XLEN-1:0] rem_i,
    input  logic            qbit_i,
    input  logic [XLEN-1:0] div_i,
    output logic [XLEN-1:0] rem_o,
    output logic            qbit_o
);
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] diff;
    logic            no_borrow;

    assign shifted = {rem_i[XLEN-2:0], qbit_i};

    add64 u_sub (
        .a_i    (shifted),
        .b_i    (~div_i),
        .cin_i  (1'b1),
        .sum_o  (diff),
        .cout_o (no_borrow)
    );

    // The bit shifted out of rem_i is the 65th bit of the trial dividend: if set it always exceeds div_i.
    assign qbit_o = rem_i[XLEN-1] | no_borrow;
    assign rem_o  = qbit_o ? diff : shifted;
endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider for DIV/DIVU/REM/REMU
// DIV_UNIT_WORD_EN adds the 32-bit W variants through the interface word signal.
module div_unit
    import div_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    div_unit_if.slave  bus
);
    state_e           state_q;
    logic             busy_q, done_q, rem_op_q, qneg_q, rneg_q;
    logic [XLEN-1:0]  rem_q, quo_q, bmag_q, s_q;
    logic [CNT_W-1:0] cnt_q, last_cnt;

    logic             sgn, rem_op, a_neg, b_neg, div_zero, ovf, w;
    logic [XLEN-1:0]  a_x, b_x, a_mag, b_mag, preload_d, spec_res_d, fix_res_d;
    logic [XLEN-1:0]  step_rem, quo_fix, rem_fix;
    logic             step_q;

    always_comb begin
        sgn    = 1'b0;
        rem_op = 1'b0;
        case (bus.func)
            DIV_OP:  begin sgn = 1'b1; rem_op = 1'b0; end
            DIVU_OP: begin sgn = 1'b0; rem_op = 1'b0; end
            REM_OP:  begin sgn = 1'b1; rem_op = 1'b1; end
            default: begin sgn = 1'b0; rem_op = 1'b1; end
        endcase
    end

`ifdef DIV_UNIT_WORD_EN
    logic w_q;

    function automatic logic [XLEN-1:0] ext_w(input logic [XLEN-1:0] x, input logic sx);
        return {{(XLEN-32){sx & x[31]}}, x[31:0]};
    endfunction

    assign w        = bus.word;
    assign a_x      = w ? ext_w(bus.a, sgn) : bus.a;
    assign b_x      = w ? ext_w(bus.b, sgn) : bus.b;
    assign ovf      = sgn & (w ? (bus.a[31:0] == 32'h8000_0000 && bus.b[31:0] == 32'hFFFF_FFFF)
                               : (bus.a == INT_MIN && bus.b == ALL_ONES));
    assign last_cnt = w_q ? CNT_W'(31) : CNT_W'(ITER-1);
`else
    assign w        = 1'b0;
    assign a_x      = bus.a;
    assign b_x      = bus.b;
    assign ovf      = sgn & (bus.a == INT_MIN) & (bus.b == ALL_ONES);
    assign last_cnt = CNT_W'(ITER-1);
`endif

    assign a_neg    = sgn & a_x[XLEN-1];
    assign b_neg    = sgn & b_x[XLEN-1];
    assign a_mag    = a_neg ? -a_x : a_x;
    assign b_mag    = b_neg ? -b_x : b_x;
    assign div_zero = (b_x == '0);

    // Word operands sit in the upper half so 32 iterations leave the quotient in the low half.
    assign preload_d = w ? {a_mag[31:0], 32'd0} : a_mag;

    always_comb begin
        spec_res_d = rem_op ? (div_zero ? a_x : '0) : (div_zero ? ALL_ONES : a_x);
        quo_fix    = qneg_q ? -quo_q : quo_q;
        rem_fix    = rneg_q ? -rem_q : rem_q;
        fix_res_d  = rem_op_q ? rem_fix : quo_fix;
`ifdef DIV_UNIT_WORD_EN
        if (w)   spec_res_d = ext_w(spec_res_d, 1'b1);
        if (w_q) fix_res_d  = ext_w(fix_res_d, 1'b1);
`endif
    end

    div_step u_step (
        .rem_i  (rem_q),
        .qbit_i (quo_q[XLEN-1]),
        .div_i  (bmag_q),
        .rem_o  (step_rem),
        .qbit_o (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rem_op_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            bmag_q   <= '0;
            s_q      <= '0;
            cnt_q    <= '0;
`ifdef DIV_UNIT_WORD_EN
            w_q      <= 1'b0;
`endif
        end else if (bus.kill && state_q != IDLE) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.start && !bus.kill) begin
                    busy_q   <= 1'b1;
                    rem_op_q <= rem_op;
                    qneg_q   <= a_neg ^ b_neg;
                    rneg_q   <= a_neg;
`ifdef DIV_UNIT_WORD_EN
                    w_q      <= w;
`endif
                    if (div_zero || ovf) begin
                        s_q     <= spec_res_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        rem_q   <= '0;
                        quo_q   <= preload_d;
                        bmag_q  <= b_mag;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    rem_q <= step_rem;
                    quo_q <= {quo_q[XLEN-2:0], step_q};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == last_cnt) state_q <= FIX;
                end
                FIX: begin
                    s_q     <= fix_res_d;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.s    = s_q;
endmodule
